mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 64-bit-wide, variable-latency backing memory port between the
//  instruction-fetch (IF) requester and the data (MEM-stage) requester of the
//  64-bit pipelined CPU. Serves one transaction at a time: arbitrate, forward
//  to memory, wait for mem_ack, return the response. Data port has priority.
//  A starvation guard bounds how long IF can lose to the data port.
// PARAMETERS
//  STARVE_MAX  4    consecutive contested losses by IF before IF is forced to win (>=1)
//  TIMEOUT     255  BUSY cycles without mem_ack before abort (only with ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  if_req     in   1   IF request; held with if_addr until if_gnt=1
//  if_addr    in   64  IF byte address
//  if_gnt     out  1   1-cycle pulse: IF request accepted
//  if_rvalid  out  1   1-cycle pulse: if_rdata/if_err valid
//  if_rdata   out  32  fetched instruction word
//  if_err     out  1   IF transaction aborted by timeout
//  d_req      in   1   data request; held with d_we/d_addr/d_wdata until d_gnt=1
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   64  data byte address
//  d_wdata    in   64  store data
//  d_gnt      out  1   1-cycle pulse: data request accepted
//  d_rvalid   out  1   1-cycle pulse: load data valid / store complete
//  d_rdata    out  64  load data
//  d_err      out  1   data transaction aborted by timeout
//  mem_req    out  1   memory request; stable until mem_ack
//  mem_we     out  1   memory write enable
//  mem_addr   out  64  8-byte-aligned address {addr[63:3],3'b000}
//  mem_wdata  out  64  memory write data
//  mem_ack    in   1   memory completion (1 cycle); ignored unless state BUSY
//  mem_rdata  in   64  read data, valid with mem_ack
// BEHAVIOUR
//  States: IDLE, BUSY. All outputs registered. Reset: state=IDLE, every output 0,
//   starvation and timeout counters 0. rst mid-transaction abandons it: mem_req
//   drops at the next edge, no rvalid is ever issued for it.
//  IDLE, at an edge with any req: latch winner's owner/we/addr/wdata, go to BUSY.
//   Next cycle: winner's gnt=1 for exactly that cycle, mem_req=1.
//  Winner: only one req -> that one. Both -> data, unless starve_cnt==STARVE_MAX,
//   then IF. starve_cnt: +1 when both request and data wins; cleared when IF wins;
//   never exceeds STARVE_MAX.
//  BUSY: mem_req/mem_we/mem_addr/mem_wdata held. Edge with mem_ack=1 -> IDLE;
//   next cycle owner's rvalid=1. IF: if_rdata = addr[2] ? mem_rdata[63:32]
//   : mem_rdata[31:0]. Data load: d_rdata = mem_rdata. Store: d_rvalid pulses,
//   d_rdata holds its previous value.
//  rdata outputs hold until next rvalid for the same port.
//  Min latency: req sampled at edge 0 -> gnt+mem_req cycle 1 -> ack in cycle 1
//   -> rvalid cycle 2. A new request can be accepted in the same cycle that
//   rvalid is high (back-to-back: one IDLE cycle per transaction).
//  Requester drops or changes req in the cycle after gnt. Holding req through
//   gnt issues a second request (by design).
//  Requests present while BUSY are not accepted and are not lost; the
//   requester keeps holding them.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: cycle counter runs in BUSY, cleared on entry.
//   Reaching TIMEOUT cycles without mem_ack: mem_req drops, state -> IDLE, owner's
//   rvalid=1 with err=1 and rdata=0 (32/64-bit). If mem_ack arrives in the
//   timeout cycle, the ack wins (normal completion, err=0).
//  ARB_TIMEOUT_EN undefined: no counter, BUSY waits forever, if_err=d_err=0.
// TESTING
//  IF only, if_addr=0x104, ack after 3 cycles, mem_rdata=0xAABBCCDD_11223344
//   -> mem_addr=0x100, if_gnt at cycle 1, if_rvalid at cycle 5 with if_rdata=0xAABBCCDD.
//  Both req same edge, d_we=1, d_addr=0x20, d_wdata=0x55 -> d_gnt first, mem_we=1,
//   mem_wdata=0x55; IF served next; d_rdata unchanged.
//  if_req and d_req held continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
//  rst pulsed while BUSY before ack -> next cycle mem_req=0, all gnt/rvalid=0;
//   late mem_ack ignored; no rvalid.
//  ARB_TIMEOUT_EN, TIMEOUT=8, no ack -> mem_req drops after 8 BUSY cycles,
//   d_rvalid=1, d_err=1, d_rdata=0. Ack on cycle 8 -> err=0, data returned.
//  Back-to-back: ack every first BUSY cycle, 10 IF requests -> one rvalid every
//   2 cycles, addresses in order.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit variable-latency memory port between the IF and data requesters.
// Define ARB_TIMEOUT_EN to abort BUSY transactions that see no mem_ack within TIMEOUT cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing outstanding; arbitrate any pending request at the edge
// BUSY  | winner's request driven on the memory port; waiting for mem_ack
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_param_check
    $error("mem_port_arbiter: STARVE_MAX and TIMEOUT must both be >= 1");
  end

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          sel_hi_q, sel_hi_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          if_gnt_d, d_gnt_d;
  logic          if_rvalid_d, d_rvalid_d;
  logic          if_err_d, d_err_d;
  logic [31:0]   if_rdata_d;
  logic [63:0]   d_rdata_d;
  logic          mem_req_d, mem_we_d;
  logic [63:0]   mem_addr_d, mem_wdata_d;

`ifdef ARB_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  // Down-counter: loaded on BUSY entry, terminal count 0 marks the last BUSY cycle.
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Byte-lane offsets below the 64-bit word are not needed on the memory side.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{d_addr[2:0], if_addr[1:0]};

  logic d_wins;
  assign d_wins = d_req && !(if_req && (starve_q == STARVE_LIM));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    sel_hi_d    = sel_hi_q;
    starve_d    = starve_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
`ifdef ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d   = S_BUSY;
          mem_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          tmo_d     = TMO_LOAD;
`endif
          if (d_wins) begin
            owner_d     = OWN_D;
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = {d_addr[63:3], 3'b000};
            mem_wdata_d = d_wdata;
            if (if_req) begin
              starve_d = starve_q + SW'(1);
            end
          end else begin
            owner_d     = OWN_IF;
            if_gnt_d    = 1'b1;
            sel_hi_d    = if_addr[2];
            mem_we_d    = 1'b0;
            mem_addr_d  = {if_addr[63:3], 3'b000};
            mem_wdata_d = '0;
            starve_d    = '0;
          end
        end
      end

      S_BUSY: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
          end else begin
            d_rvalid_d = 1'b1;
            if (!mem_we) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_err_d    = 1'b1;
            if_rdata_d  = '0;
          end else begin
            d_rvalid_d = 1'b1;
            d_err_d    = 1'b1;
            d_rdata_d  = '0;
          end
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
`endif
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_IF;
      sel_hi_q  <= 1'b0;
      starve_q  <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_err    <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      sel_hi_q  <= sel_hi_d;
      starve_q  <= starve_d;
      if_gnt    <= if_gnt_d;
      d_gnt     <= d_gnt_d;
      if_rvalid <= if_rvalid_d;
      d_rvalid  <= d_rvalid_d;
      if_err    <= if_err_d;
      d_err     <= d_err_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors plus multi-cycle sequences for mem_port_arbiter.
// Timeout sequence depends on ARB_TIMEOUT_EN (TIMEOUT=8 in this bench).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [63:0] d_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          delay;
    logic [63:0] rdata;
    logic [63:0] exp_maddr;
    logic [31:0] exp_if;
    logic [63:0] exp_d;
  } vec_t;

  vec_t vecs[5];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] order_exp;
    int n;
    int last_rv;
    logic [63:0] b2b_base;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    vecs[0] = '{1'b0, 1'b0, 64'h104, 64'h0, 3, 64'hAABBCCDD_11223344,
                64'h100, 32'hAABBCCDD, 64'h0};
    vecs[1] = '{1'b0, 1'b0, 64'h1000, 64'h0, 0, 64'h01234567_89ABCDEF,
                64'h1000, 32'h89ABCDEF, 64'h0};
    vecs[2] = '{1'b1, 1'b0, 64'h2F, 64'h0, 1, 64'hDEADBEEF_CAFEF00D,
                64'h28, 32'h89ABCDEF, 64'hDEADBEEF_CAFEF00D};
    vecs[3] = '{1'b1, 1'b1, 64'h20, 64'h55, 0, 64'hFFFFFFFF_FFFFFFFF,
                64'h20, 32'h89ABCDEF, 64'hDEADBEEF_CAFEF00D};
    vecs[4] = '{1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 64'h0, 2, 64'h11112222_33334444,
                64'hFFFFFFFF_FFFFFFF8, 32'h11112222, 64'hDEADBEEF_CAFEF00D};

    cyc(); cyc();
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_pulses", {60'd0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 64'd0);
    chk("rst_err", {62'd0, if_err, d_err}, 64'd0);
    chk("rst_rdata", d_rdata | {32'd0, if_rdata}, 64'd0);
    chk("rst_mem_bus", mem_addr | mem_wdata | {63'd0, mem_we}, 64'd0);
    rst = 1'b0;
    cyc();

    // Single transactions from the vector table
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].is_d) begin
        d_req = 1'b1; d_we = vecs[i].we; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end
      cyc();
      chk($sformatf("v%0d_gnt", i), {62'd0, d_gnt, if_gnt}, vecs[i].is_d ? 64'd2 : 64'd1);
      chk($sformatf("v%0d_mem_req", i), {63'd0, mem_req}, 64'd1);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_maddr);
      chk($sformatf("v%0d_mem_we", i), {63'd0, mem_we}, {63'd0, vecs[i].we});
      if (vecs[i].we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
      if_req = 1'b0; d_req = 1'b0;
      for (int k = 0; k < vecs[i].delay; k++) begin
        cyc();
        chk($sformatf("v%0d_wait%0d_req", i, k), {63'd0, mem_req}, 64'd1);
        chk($sformatf("v%0d_wait%0d_quiet", i, k), {60'd0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 64'd0);
      end
      mem_ack = 1'b1; mem_rdata = vecs[i].rdata;
      cyc();
      mem_ack = 1'b0;
      chk($sformatf("v%0d_rvalid", i), {62'd0, d_rvalid, if_rvalid}, vecs[i].is_d ? 64'd2 : 64'd1);
      chk($sformatf("v%0d_mem_req_drop", i), {63'd0, mem_req}, 64'd0);
      chk($sformatf("v%0d_if_rdata", i), {32'd0, if_rdata}, {32'd0, vecs[i].exp_if});
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].exp_d);
      chk($sformatf("v%0d_err", i), {62'd0, if_err, d_err}, 64'd0);
    end

    // Contested same-edge request: data store first, then IF
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h20; d_wdata = 64'h55;
    if_req = 1'b1; if_addr = 64'h104;
    cyc();
    chk("both_d_gnt", {62'd0, d_gnt, if_gnt}, 64'd2);
    chk("both_mem_we", {63'd0, mem_we}, 64'd1);
    chk("both_mem_wdata", mem_wdata, 64'h55);
    d_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 64'h12345678_9ABCDEF0;
    cyc();
    mem_ack = 1'b0;
    chk("both_d_rvalid", {63'd0, d_rvalid}, 64'd1);
    chk("both_d_rdata_kept", d_rdata, 64'hDEADBEEF_CAFEF00D);
    cyc();
    chk("both_if_gnt", {62'd0, d_gnt, if_gnt}, 64'd1);
    chk("both_if_mem_addr", mem_addr, 64'h100);
    if_req = 1'b0;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("both_if_rvalid", {63'd0, if_rvalid}, 64'd1);
    chk("both_if_rdata", {32'd0, if_rdata}, 64'h12345678);

    // Starvation guard: both held, ack every first BUSY cycle
    order_exp = 10'b10_0001_0000;
    if_req = 1'b1; if_addr = 64'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
    mem_ack = 1'b1; mem_rdata = 64'h0;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      cyc();
      if (if_gnt || d_gnt) begin
        chk($sformatf("starve_order%0d", n), {63'd0, if_gnt}, {63'd0, order_exp[n]});
        chk($sformatf("starve_single%0d", n), {63'd0, if_gnt & d_gnt}, 64'd0);
        n++;
        if (n == 10) begin
          if_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    chk("starve_count", 64'(n), 64'd10);
    if_req = 1'b0; d_req = 1'b0;
    cyc();
    mem_ack = 1'b0;
    cyc();

    // Back-to-back IF fetches: one rvalid every 2 cycles, addresses in order
    b2b_base = 64'h4000;
    if_req = 1'b1; if_addr = b2b_base; mem_ack = 1'b1;
    n = 0; last_rv = -1;
    begin
      int n_rv;
      n_rv = 0;
      for (int c = 0; c < 60 && n_rv < 10; c++) begin
        cyc();
        if (if_gnt) begin
          chk($sformatf("b2b_addr%0d", n), mem_addr, b2b_base + 64'(8 * n));
          mem_rdata = {32'hC0DE0000 | 32'(n), 32'h0000A000 | 32'(n)};
          n++;
          if (n < 10) if_addr = b2b_base + 64'(8 * n);
          else if_req = 1'b0;
        end
        if (if_rvalid) begin
          chk($sformatf("b2b_data%0d", n_rv), {32'd0, if_rdata}, {32'd0, 32'h0000A000 | 32'(n_rv)});
          if (n_rv > 0) chk($sformatf("b2b_gap%0d", n_rv), 64'(c - last_rv), 64'd2);
          last_rv = c;
          n_rv++;
        end
      end
      chk("b2b_count", 64'(n_rv), 64'd10);
    end
    if_req = 1'b0; mem_ack = 1'b0;
    cyc();

    // Reset while BUSY abandons the transaction; a late ack is ignored
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h80;
    cyc();
    chk("rstbusy_gnt", {63'd0, d_gnt}, 64'd1);
    d_req = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstbusy_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rstbusy_pulses", {60'd0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h77;
    cyc();
    mem_ack = 1'b0;
    chk("rstbusy_late_ack1", {61'd0, mem_req, if_rvalid, d_rvalid}, 64'd0);
    cyc();
    chk("rstbusy_late_ack2", {61'd0, mem_req, if_rvalid, d_rvalid}, 64'd0);
    chk("rstbusy_d_rdata", d_rdata, 64'd0);

`ifdef ARB_TIMEOUT_EN
    // Ack in the 8th BUSY cycle beats the timeout
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    cyc();
    d_req = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      cyc();
      chk($sformatf("tmo_ack_wait%0d", k), {62'd0, mem_req, d_rvalid}, 64'd2);
    end
    mem_ack = 1'b1; mem_rdata = 64'h0BADF00D_12345678;
    cyc();
    mem_ack = 1'b0;
    chk("tmo_ack_rvalid", {62'd0, d_rvalid, d_err}, 64'd2);
    chk("tmo_ack_rdata", d_rdata, 64'h0BADF00D_12345678);
    // No ack: abort after 8 BUSY cycles
    d_req = 1'b1; d_addr = 64'h48;
    cyc();
    d_req = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      cyc();
      chk($sformatf("tmo_wait%0d", k), {62'd0, mem_req, d_rvalid}, 64'd2);
    end
    cyc();
    chk("tmo_abort_req", {63'd0, mem_req}, 64'd0);
    chk("tmo_abort_rvalid_err", {62'd0, d_rvalid, d_err}, 64'd3);
    chk("tmo_abort_rdata", d_rdata, 64'd0);
    cyc();
    chk("tmo_err_pulse", {62'd0, d_rvalid, d_err}, 64'd0);
`else
    // Without the timeout, BUSY waits indefinitely for mem_ack
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    cyc();
    d_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk($sformatf("notmo_wait%0d", k), {61'd0, mem_req, d_rvalid, d_err}, 64'd4);
    end
    mem_ack = 1'b1; mem_rdata = 64'h0BADF00D_12345678;
    cyc();
    mem_ack = 1'b0;
    chk("notmo_rvalid", {62'd0, d_rvalid, d_err}, 64'd2);
    chk("notmo_rdata", d_rdata, 64'h0BADF00D_12345678);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
